// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state encodings and flag bit indices for mdu_iter
package mdu_pkg;
  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_MLA   = 3'b011;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement of a WIDTH-bit value
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);
  assign out = neg ? -in : in;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiply / restoring divide unit with start/done handshake
// Optional: define MDU_EARLY_OUT_EN to let multiplies leave RUN once the multiplier is exhausted
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       mdu_flags,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [W2-1:0]    r_acc, r_sh;
  logic [WIDTH-1:0] r_mplr, r_lo, r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q, r_neg_r, r_done, r_dz;
  logic [3:0]       r_fl, r_flags;
  logic [2:0]       w_op;
  logic             w_sgn, w_div, w_dz, w_skip, w_last, w_ge, w_long, w_r_div;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_sub, w_rem;
  logic [WIDTH:0]   w_rem_sh;
  logic [W2-1:0]    w_div_nx, w_mul_nx, w_fix_in, w_fix, w_res;
  logic [3:0]       w_fl;
  assign w_op  = (op[2:1] == 2'b11) ? OP_MUL : op;
  assign w_sgn = (w_op == OP_SMULL) || (w_op == OP_SDIV);
  assign w_div = w_op[2];
  assign w_dz  = w_div && (b == '0);
  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.in(a), .neg(w_sgn & a[WIDTH-1]), .out(w_abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.in(b), .neg(w_sgn & b[WIDTH-1]), .out(w_abs_b));
  assign w_r_div  = r_op[2];
  // Divide step: r_acc = {remainder, dividend/quotient}, shifted left one bit per cycle
  assign w_rem_sh  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_sh[WIDTH-1:0]};
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_sh[WIDTH-1:0];
  assign w_div_nx  = {w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
  // Multiply step: multiplicand shifts left in r_sh, so the accumulator never needs realigning
  assign w_mul_nx  = r_acc + (r_mplr[0] ? r_sh : '0);
`ifdef MDU_EARLY_OUT_EN
  assign w_skip = (b == '0);
  assign w_last = (r_cnt == CNT_W'(1)) || (!w_r_div && (r_mplr[WIDTH-1:1] == '0));
`else
  assign w_skip = w_dz;
  assign w_last = (r_cnt == CNT_W'(1));
`endif
  assign w_fix_in = w_r_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;
  mdu_negate #(.WIDTH(W2))    u_fix (.in(w_fix_in), .neg(r_neg_q), .out(w_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_rem (.in(r_acc[W2-1:WIDTH]), .neg(r_neg_r), .out(w_rem));
  assign w_res  = r_dz ? r_acc : w_r_div ? {w_rem, w_fix[WIDTH-1:0]} : w_fix;
  assign w_long = (r_op == OP_UMULL) || (r_op == OP_SMULL);
  always_comb begin
    w_fl = '0;
    w_fl[F_N] = w_long ? w_res[W2-1] : w_res[WIDTH-1];
    w_fl[F_Z] = w_long ? (w_res == '0) : (w_res[WIDTH-1:0] == '0);
    w_fl[F_C] = !w_r_div && !w_long && (w_res[W2-1:WIDTH] != '0);
    w_fl[F_V] = (r_op == OP_SDIV) && !r_dz && !r_neg_q &&
                (r_acc[WIDTH-1:0] == {1'b1, {(WIDTH-1){1'b0}}});
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= w_op;
          r_acc   <= w_dz ? {a, {WIDTH{1'b0}}} : w_div ? {{WIDTH{1'b0}}, w_abs_a} :
                     (w_op == OP_MLA) ? {{WIDTH{1'b0}}, c} : '0;
          r_sh    <= {{WIDTH{1'b0}}, w_div ? w_abs_b : w_abs_a};
          r_mplr  <= w_abs_b;
          r_cnt   <= CNT_W'(WIDTH);
          r_neg_q <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_r <= w_sgn & a[WIDTH-1];
          r_dz    <= w_dz;
          r_state <= w_skip ? S_FIX : S_RUN;
        end
        S_RUN: begin
          r_acc   <= w_r_div ? w_div_nx : w_mul_nx;
          r_sh    <= w_r_div ? r_sh : {r_sh[W2-2:0], 1'b0};
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt - CNT_W'(1);
          r_state <= w_last ? S_FIX : S_RUN;
        end
        S_FIX: begin
          r_acc   <= w_res;
          r_fl    <= w_fl;
          r_state <= S_DONE;
        end
        default: begin
          r_lo    <= r_acc[WIDTH-1:0];
          r_hi    <= r_acc[W2-1:WIDTH];
          r_flags <= r_fl;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign busy      = (r_state == S_RUN) || (r_state == S_FIX);
  assign done      = r_done;
  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign mdu_flags = r_flags;
  assign div_zero  = r_dz;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter at WIDTH=32; expected latency follows MDU_EARLY_OUT_EN
module tb_mdu_iter;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
    logic [3:0]  mask;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        busy, done, div_zero;
  logic [31:0] result_lo, result_hi;
  logic [3:0]  mdu_flags;
  int n_checks = 0, n_fail = 0, n_done = 0, cyc = 0;
  exp_t sb[$];
  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .mdu_flags(mdu_flags), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int lat_of(input logic [2:0] o, input logic [31:0] bb);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
    int h;
    if (o[2:1] == 2'b10) return (bb == 0) ? 2 : 34;
    m = (o == 3'b010 && bb[31]) ? -bb : bb;
    if (m == 0) return 2;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return h + 3;
`else
    if (o[2:1] == 2'b10) return (bb == 0) ? 2 : 34;
    return 34;
`endif
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result_lo", result_lo, e.lo);
        chk("result_hi", result_hi, e.hi);
        chk("flags", mdu_flags & e.mask, e.fl & e.mask);
        chk("div_zero", div_zero, e.dz);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end
  task automatic push_exp(input logic [2:0] o, input logic [31:0] bb, input logic [31:0] elo, ehi,
                          input logic [3:0] efl, emask, input logic edz);
    exp_t e;
    e.lo = elo; e.hi = ehi; e.fl = efl; e.mask = emask; e.dz = edz;
    e.lat = lat_of(o, bb);
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask
  task automatic do_op(input logic [2:0] o, input logic [31:0] aa, bb, cc, elo, ehi,
                       input logic [3:0] efl, emask, input logic edz);
    int d0;
    @(negedge clk);
    op = o; a = aa; b = bb; c = cc; start = 1'b1;
    push_exp(o, bb, elo, ehi, efl, emask, edz);
    d0 = n_done;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; c = $urandom; op = 3'($urandom);
    chk("busy_after_accept", busy, 1);
    for (int t = 0; t < 100 && n_done == d0; t++) @(negedge clk);
    chk("done_seen", n_done != d0, 1);
  endtask
  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_flags", mdu_flags, 0);
    chk("rst_dz", div_zero, 0);
    reset = 1'b1;
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000, 4'b1101, 0);
    do_op(3'b010, -32'sd3, 32'd7, 0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b1000, 4'b1101, 0);
    do_op(3'b011, 32'd5, 32'd6, 32'd100, 32'd130, 32'd0, 4'b0000, 4'b1111, 0);
    do_op(3'b101, -32'sd7, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 4'b1111, 0);
    do_op(3'b101, 32'd7, -32'sd2, 0, 32'hFFFF_FFFD, 32'd1, 4'b1000, 4'b1111, 0);
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 4'b1001, 4'b1111, 0);
    do_op(3'b100, 32'd100, 32'd7, 0, 32'd14, 32'd2, 4'b0000, 4'b1111, 0);
    do_op(3'b100, 32'd42, 32'd0, 0, 32'd0, 32'd42, 4'b0100, 4'b1111, 1);
    do_op(3'b000, 32'd9, 32'd3, 0, 32'd27, 32'd0, 4'b0000, 4'b1111, 0);
    do_op(3'b000, 32'h0001_0000, 32'h0001_0000, 0, 32'd0, 32'd1, 4'b0110, 4'b1111, 0);
    do_op(3'b110, 32'd3, 32'd4, 0, 32'd12, 32'd0, 4'b0000, 4'b1111, 0);
    do_op(3'b000, 32'd5, 32'd0, 0, 32'd0, 32'd0, 4'b0100, 4'b1111, 0);
    // start held high throughout the operation must not queue a second one
    @(negedge clk);
    op = 3'b001; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 0; start = 1'b1;
    push_exp(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000, 4'b1101, 0);
    d0 = n_done;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("single_done", n_done - d0, 1);
    @(negedge clk);
    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = n_done;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lo", result_lo, 0);
    chk("mid_rst_hi", result_hi, 0);
    chk("mid_rst_flags", mdu_flags, 0);
    chk("mid_rst_dz", div_zero, 0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", n_done - d0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
